psum_accum: RTL and testbench

PSUM_ACCUM -- requirements
Module: psum_accum

---
 rtl/psum_accum_if.sv | 33 +++
 rtl/psum_accum.sv | 147 ++++++++++++++
 tb/tb_psum_accum.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/psum_accum_if.sv
// Job control, psum input and result output bundle of psum_accum.
// The master modport drives job config, psums and out_ready; the slave (accumulator) returns results and status.
interface psum_accum_if #(
    parameter int PSUM_BW = 9,
    parameter int ACC_BW  = 16
);
    logic                      start;
    logic                      cfg_mode;
    logic [3:0]                cfg_passes;
    logic                      cfg_relu;
    logic                      in_valid;
    logic signed [PSUM_BW-1:0] in_s0;
    logic signed [PSUM_BW-1:0] in_s1;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [ACC_BW-1:0]  out_d0;
    logic signed [ACC_BW-1:0]  out_d1;
    logic                      busy;
    logic                      done;
    logic                      ovf;

    modport master (
        output start, cfg_mode, cfg_passes, cfg_relu,
        output in_valid, in_s0, in_s1, out_ready,
        input  out_valid, out_d0, out_d1, busy, done, ovf
    );

    modport slave (
        input  start, cfg_mode, cfg_passes, cfg_relu,
        input  in_valid, in_s0, in_s1, out_ready,
        output out_valid, out_d0, out_d1, busy, done, ovf
    );
endinterface

// File: rtl/psum_accum.sv
// Multi-pass saturating partial-sum accumulator, DEPTH entries x 2 lanes; input lands one cycle after sampling.
// Drain is valid/ready: out_valid from the first DRAIN cycle, data held while out_ready is low; inputs never stall.
module psum_accum #(
    parameter int PSUM_BW = 9,
    parameter int ACC_BW  = 16,
    parameter int DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    psum_accum_if.slave io
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};
    localparam logic [PW-1:0]     LAST_ENTRY = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q;
    logic              relu_q;
    logic [3:0]        last_pass_q;
    logic [3:0]        pass_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic              ovf_q;
    logic              done_q;
    logic [ACC_BW-1:0] acc0_q [DEPTH];
    logic [ACC_BW-1:0] acc1_q [DEPTH];

    // Returns {saturated, value}; the extra sum bit exposes signed overflow.
    function automatic logic [ACC_BW:0] sat_add(input logic [ACC_BW-1:0] a,
                                                input logic [ACC_BW-1:0] b);
        logic [ACC_BW:0] s;
        s = {a[ACC_BW-1], a} + {b[ACC_BW-1], b};
        if (s[ACC_BW] != s[ACC_BW-1]) begin
            return {1'b1, (s[ACC_BW] ? ACC_MIN : ACC_MAX)};
        end
        return {1'b0, s[ACC_BW-1:0]};
    endfunction

    logic [ACC_BW-1:0] s0_x, s1_x;
    logic [ACC_BW-1:0] contrib0, contrib1;
    logic [ACC_BW:0]   sum0, sum1;
    logic [ACC_BW-1:0] new0, new1;
    logic              sat_hit;
    logic              first_pass;
    logic              acc_we;
    logic              wrap;
    logic              last_in;
    logic              hs;
    logic              last_out;

    assign s0_x = {{(ACC_BW-PSUM_BW){io.in_s0[PSUM_BW-1]}}, io.in_s0};
    assign s1_x = {{(ACC_BW-PSUM_BW){io.in_s1[PSUM_BW-1]}}, io.in_s1};

    // ACC_BW >= PSUM_BW+3 keeps the combined 4-bit contribution exact.
    assign contrib0 = mode_q ? (s0_x + (s1_x << 2)) : s0_x;
    assign contrib1 = mode_q ? '0 : s1_x;

    assign sum0       = sat_add(acc0_q[wr_ptr_q], contrib0);
    assign sum1       = sat_add(acc1_q[wr_ptr_q], contrib1);
    assign first_pass = (pass_q == 4'd0);
    assign new0       = first_pass ? contrib0 : sum0[ACC_BW-1:0];
    assign new1       = first_pass ? contrib1 : sum1[ACC_BW-1:0];
    assign sat_hit    = !first_pass && (sum0[ACC_BW] || sum1[ACC_BW]);

    assign acc_we   = (state_q == S_ACCUM) && io.in_valid;
    assign wrap     = (wr_ptr_q == LAST_ENTRY);
    assign last_in  = acc_we && wrap && (pass_q == last_pass_q);
    assign hs       = (state_q == S_DRAIN) && io.out_ready;
    assign last_out = hs && (rd_ptr_q == LAST_ENTRY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (io.start) state_d = S_ACCUM;
            S_ACCUM: if (last_in)  state_d = S_DRAIN;
            S_DRAIN: if (last_out) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            relu_q      <= 1'b0;
            last_pass_q <= 4'd0;
            pass_q      <= 4'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= last_out;
            if (state_q == S_IDLE && io.start) begin
                mode_q      <= io.cfg_mode;
                relu_q      <= io.cfg_relu;
                last_pass_q <= (io.cfg_passes == 4'd0) ? 4'd0 : (io.cfg_passes - 4'd1);
                pass_q      <= 4'd0;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                ovf_q       <= 1'b0;
            end
            if (acc_we) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (wrap) begin
                    pass_q <= pass_q + 4'd1;
                end
                if (sat_hit) begin
                    ovf_q <= 1'b1;
                end
            end
            if (hs) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage is not reset: pass 0 always overwrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (acc_we) begin
            acc0_q[wr_ptr_q] <= new0;
            acc1_q[wr_ptr_q] <= new1;
        end
    end

    logic [ACC_BW-1:0] rd0, rd1;
    logic              drain;

    assign drain = (state_q == S_DRAIN);
    assign rd0   = acc0_q[rd_ptr_q];
    assign rd1   = acc1_q[rd_ptr_q];

    assign io.out_valid = drain;
    assign io.out_d0    = (!drain || (relu_q && rd0[ACC_BW-1])) ? '0 : rd0;
    assign io.out_d1    = (!drain || (relu_q && rd1[ACC_BW-1])) ? '0 : rd1;
    assign io.busy      = (state_q != S_IDLE);
    assign io.done      = done_q;
    assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_psum_accum.sv
// Randomized and directed bench for psum_accum with a job-level reference model checked every cycle.
module tb_psum_accum;
    localparam int PSUM_BW = 9;
    localparam int ACC_BW  = 12;
    localparam int DEPTH   = 8;
    localparam int MAXV    = (1 << (ACC_BW - 1)) - 1;
    localparam int MINV    = -(1 << (ACC_BW - 1));

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    psum_accum_if #(.PSUM_BW(PSUM_BW), .ACC_BW(ACC_BW)) io();

    psum_accum #(.PSUM_BW(PSUM_BW), .ACC_BW(ACC_BW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: job phase, input count, drained count and per-entry lane sums as plain ints.
    int m_phase = 0;
    int m_cnt   = 0;
    int m_npass = 1;
    int m_rd    = 0;
    bit m_mode  = 1'b0;
    bit m_relu  = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_done  = 1'b0;
    int m_e0 [DEPTH];
    int m_e1 [DEPTH];

    function automatic int clampv(input int v);
        return (v > MAXV) ? MAXV : ((v < MINV) ? MINV : v);
    endfunction

    function automatic int relu_f(input int v, input bit r);
        return (r && v < 0) ? 0 : v;
    endfunction

    initial begin
        int k, a, b, c0, c1, s0, s1;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_phase = 0; m_ovf = 1'b0; m_done = 1'b0; m_rd = 0;
            end else begin
                m_done = 1'b0;
                case (m_phase)
                    0: if (io.start) begin
                        m_mode  = io.cfg_mode;
                        m_relu  = io.cfg_relu;
                        m_npass = (io.cfg_passes == 4'd0) ? 1 : int'(io.cfg_passes);
                        m_cnt   = 0;
                        m_ovf   = 1'b0;
                        m_phase = 1;
                    end
                    1: if (io.in_valid) begin
                        k = m_cnt % DEPTH;
                        a = int'($signed(io.in_s0));
                        b = int'($signed(io.in_s1));
                        if (m_mode) begin c0 = a + 4 * b; c1 = 0; end
                        else        begin c0 = a;         c1 = b; end
                        if (m_cnt < DEPTH) begin
                            m_e0[k] = c0; m_e1[k] = c1;
                        end else begin
                            s0 = m_e0[k] + c0; s1 = m_e1[k] + c1;
                            if (clampv(s0) != s0 || clampv(s1) != s1) m_ovf = 1'b1;
                            m_e0[k] = clampv(s0); m_e1[k] = clampv(s1);
                        end
                        m_cnt++;
                        if (m_cnt == DEPTH * m_npass) begin m_phase = 2; m_rd = 0; end
                    end
                    default: if (io.out_ready) begin
                        m_rd++;
                        if (m_rd == DEPTH) begin m_phase = 0; m_done = 1'b1; m_rd = 0; end
                    end
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        int e0, e1;
        forever begin
            @(negedge clk);
            e0 = (m_phase == 2) ? relu_f(m_e0[m_rd], m_relu) : 0;
            e1 = (m_phase == 2) ? relu_f(m_e1[m_rd], m_relu) : 0;
            check("busy",      io.busy,      (m_phase != 0));
            check("out_valid", io.out_valid, (m_phase == 2));
            check("out_d0",    io.out_d0,    e0);
            check("out_d1",    io.out_d1,    e1);
            check("done",      io.done,      m_done);
            check("ovf",       io.ovf,       m_ovf);
        end
    end

    // pat: 0 = s0=i, s1=-i; 1 = constants; 2 = random. stall: 0 none; 1 ready low drain cycles 1..3; 2 random noise.
    task automatic run_job(input bit mode, input int passes, input bit relu, input int pat,
                           input int c0, input int c1, input int stall,
                           input bit lit_en, input int lit0, input int lit1);
        int n, i, c, v0, v1;
        bit gap, got;
        @(posedge clk); #1;
        io.start = 1'b1; io.cfg_mode = mode; io.cfg_passes = 4'(passes); io.cfg_relu = relu;
        io.in_valid = 1'b0; io.out_ready = 1'b0;
        n = ((passes == 0) ? 1 : passes) * DEPTH;
        i = 0;
        while (i < n) begin
            @(posedge clk); #1;
            io.start    = (stall == 2) && ($urandom_range(0, 5) == 0);
            io.cfg_mode = (stall == 2) ? 1'($urandom_range(0, 1)) : mode;
            gap = (stall == 2) && ($urandom_range(0, 3) == 0);
            if (pat == 0)      begin v0 = i % DEPTH; v1 = -(i % DEPTH); end
            else if (pat == 1) begin v0 = c0; v1 = c1; end
            else begin v0 = int'($urandom_range(0, 511)); v1 = int'($urandom_range(0, 511)); end
            io.in_s0 = v0[PSUM_BW-1:0];
            io.in_s1 = v1[PSUM_BW-1:0];
            io.in_valid = !gap;
            if (!gap) i++;
        end
        @(posedge clk); #1;
        io.in_valid = 1'b0; io.start = 1'b0;
        got = 1'b0; c = 0;
        while (!got && c < 400) begin
            if (stall == 0)      io.out_ready = 1'b1;
            else if (stall == 1) io.out_ready = !(c >= 1 && c <= 3);
            else                 io.out_ready = ($urandom_range(0, 2) != 0);
            io.in_valid = (stall == 2) && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (c == 0 && lit_en) begin
                check("lit_d0", io.out_d0, lit0);
                check("lit_d1", io.out_d1, lit1);
            end
            if (io.done) got = 1'b1;
            else begin @(posedge clk); #1; c++; end
        end
        check("done_seen", got, 1);
        io.in_valid = 1'b0;
    endtask

    initial begin
        io.start = 1'b0; io.cfg_mode = 1'b0; io.cfg_passes = 4'd0; io.cfg_relu = 1'b0;
        io.in_valid = 1'b0; io.in_s0 = '0; io.in_s1 = '0; io.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_job(1'b0, 1, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
        check("pin_e0_5", m_e0[5], 5);
        check("pin_e1_5", m_e1[5], -5);

        run_job(1'b1, 1, 1'b0, 1, -6, -2, 0, 1'b1, -14, 0);
        check("pin_m1_e0", m_e0[3], -14);
        run_job(1'b1, 1, 1'b1, 1, -6, -2, 0, 1'b1, 0, 0);

        run_job(1'b0, 3, 1'b0, 1, 100, -50, 0, 1'b1, 300, -150);
        check("pin_3pass_e1", m_e1[7], -150);

        run_job(1'b1, 2, 1'b0, 1, 255, 255, 0, 1'b1, 2047, 0);
        check("pin_sat_ovf", m_ovf, 1);
        check("ovf_sticky", io.ovf, 1);

        run_job(1'b0, 1, 1'b0, 0, 0, 0, 1, 1'b0, 0, 0);
        check("ovf_cleared", io.ovf, 0);

        run_job(1'b0, 0, 1'b0, 1, 3, 4, 0, 1'b1, 3, 4);

        // Abandon a job after four inputs, then confirm no stale data survives.
        @(posedge clk); #1;
        io.start = 1'b1; io.cfg_mode = 1'b0; io.cfg_passes = 4'd2; io.cfg_relu = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            io.start = 1'b0; io.in_valid = 1'b1; io.in_s0 = 9'd50; io.in_s1 = 9'd60;
        end
        @(posedge clk); #1;
        io.in_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        run_job(1'b0, 1, 1'b0, 1, 7, 0, 0, 1'b1, 7, 0);
        check("pin_after_rst", m_e0[6], 7);

        for (int r = 0; r < 12; r++) begin
            run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                    2, 0, 0, 2, 1'b0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
